register_forward: RTL and testbench
===================================

REGISTER_FORWARD -- requirements
Module: register_forward

Interface
REQ-001 Parameter: AW, default 5, register-number width in bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for the MEM-stage tracking registers.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 RN1  input  AW  source register number 1 of the instruction in decode.
REQ-006 RN2  input  AW  source register number 2 of the instruction in decode.
REQ-007 RN1_EX  input  AW  destination register number of the instruction in EX.
REQ-008 WriteReg_EX  input  1  EX instruction writes register RN1_EX.
REQ-009 WriteR0_EX  input  1  EX instruction implicitly writes register 0.
REQ-010 Reg_Forwarding1  output  1  forward the EX result to operand 1.
REQ-011 Reg_Forwarding2  output  1  forward the EX result to operand 2.
REQ-012 Mem_Forwarding1  output  1  forward the MEM result to operand 1.
REQ-013 Mem_Forwarding2  output  1  forward the MEM result to operand 2.

Function
REQ-014 The EX match for operand n SHALL be (WriteReg_EX and RNn == RN1_EX) or (WriteR0_EX and RNn == 0), with a full AW-bit equality compare.
- Reg_Forwarding1 SHALL equal the EX match for RN1.
- Reg_Forwarding2 SHALL equal the EX match for RN2.
REQ-015 Reg_Forwarding1/2 SHALL be purely combinational, with zero-cycle latency, and SHALL be independent of clk and rst.
REQ-016 Register 0 is a real register, not hardwired to zero: RN=0 with WriteReg_EX=1 and RN1_EX=0 SHALL forward.
REQ-017 When WriteReg_EX and WriteR0_EX are both 1, a match through either term SHALL forward.
REQ-018 When WriteReg_EX=0 and WriteR0_EX=0, both Reg_Forwarding outputs SHALL be 0 regardless of register numbers.
REQ-019 On every rising clk edge the block SHALL capture the EX writer into MEM-stage registers:
- dest_MEM <= RN1_EX
- wr_MEM <= WriteReg_EX
- r0_MEM <= WriteR0_EX
REQ-020 The MEM match for operand n SHALL be (wr_MEM and RNn == dest_MEM) or (r0_MEM and RNn == 0).
REQ-021 Mem_Forwarding_n SHALL equal (MEM match_n) and not (EX match_n), so the newest producer wins and at most one forwarding output per operand is 1.
REQ-022 Mem_Forwarding1/2 SHALL be combinational from RN1/RN2 and the MEM-stage registers.
REQ-023 The two operands SHALL be evaluated independently; RN1 == RN2 may assert both outputs of the same stage.

Reset
REQ-024 While rst=1, and immediately on its assertion (asynchronous), dest_MEM, wr_MEM and r0_MEM SHALL be 0, so Mem_Forwarding1/2 = 0.
REQ-025 Reset SHALL NOT affect Reg_Forwarding1/2, which continue to follow their inputs.
REQ-026 After rst deasserts, the first rising clk edge SHALL load the MEM-stage registers normally.
REQ-027 If rst asserts while the MEM stage holds a writer, that writer SHALL be discarded and SHALL NOT be forwarded after reset.

Verification
REQ-028 EX match, operand 1 only: RN1=0x0A, RN2=0x0F, RN1_EX=0x0A, WriteReg_EX=1, WriteR0_EX=0 -> Reg_Forwarding1=1, Reg_Forwarding2=0.
REQ-029 EX match, operand 2 only: RN1=0x05, RN2=0x0C, RN1_EX=0x0C, WriteReg_EX=1, WriteR0_EX=0 -> Reg_Forwarding1=0, Reg_Forwarding2=1.
REQ-030 Implicit R0 write: RN1=0, RN2=0, RN1_EX=0x03, WriteReg_EX=0, WriteR0_EX=1 -> both Reg_Forwarding=1; then RN1=RN2=0x03 -> both 0.
REQ-031 MEM forwarding: write 0x07 in cycle k (WriteReg_EX=1, RN1_EX=0x07); in cycle k+1 set WriteReg_EX=0, WriteR0_EX=0, RN1=0x07 -> Mem_Forwarding1=1, Reg_Forwarding1=0.
REQ-032 EX over MEM priority: MEM holds a writer of 0x07 and EX writes 0x07 with RN1=0x07 -> Reg_Forwarding1=1, Mem_Forwarding1=0.
REQ-033 Reset mid-operation: MEM holds a writer of 0x07, RN1=0x07, assert rst between clock edges -> Mem_Forwarding1 falls to 0 without waiting for a clk edge.

Source files
------------

// File: rtl/register_forward.sv
// Operand forwarding control: flags when decode-stage sources must take the EX
// or MEM result, tracking the previous EX writer in MEM-stage registers.
module register_forward #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] RN1,
   input  logic [AW-1:0] RN2,
   input  logic [AW-1:0] RN1_EX,
   input  logic          WriteReg_EX,
   input  logic          WriteR0_EX,
   output logic          Reg_Forwarding1,
   output logic          Reg_Forwarding2,
   output logic          Mem_Forwarding1,
   output logic          Mem_Forwarding2
);

   logic [AW-1:0] dest_MEM;
   logic          wr_MEM;
   logic          r0_MEM;

   logic ex_match1;
   logic ex_match2;
   logic mem_match1;
   logic mem_match2;

   // Reset clears the tracked writer so a pre-reset producer is never forwarded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dest_MEM <= '0;
         wr_MEM   <= 1'b0;
         r0_MEM   <= 1'b0;
      end else begin
         dest_MEM <= RN1_EX;
         wr_MEM   <= WriteReg_EX;
         r0_MEM   <= WriteR0_EX;
      end
   end

   // Register 0 is a real register: the implicit R0 write is a second match term.
   always_comb begin
      ex_match1  = (WriteReg_EX && (RN1 == RN1_EX)) || (WriteR0_EX && (RN1 == '0));
      ex_match2  = (WriteReg_EX && (RN2 == RN1_EX)) || (WriteR0_EX && (RN2 == '0));
      mem_match1 = (wr_MEM && (RN1 == dest_MEM)) || (r0_MEM && (RN1 == '0));
      mem_match2 = (wr_MEM && (RN2 == dest_MEM)) || (r0_MEM && (RN2 == '0));
   end

   // The EX producer is newer, so it masks any MEM match on the same operand.
   assign Reg_Forwarding1 = ex_match1;
   assign Reg_Forwarding2 = ex_match2;
   assign Mem_Forwarding1 = mem_match1 && !ex_match1;
   assign Mem_Forwarding2 = mem_match2 && !ex_match2;

endmodule

// File: tb/tb_register_forward.sv
// Self-checking bench for register_forward: scoreboard of predicted outputs
// from a reference model, plus directed checks of the key forwarding cases.
module tb_register_forward;

   localparam int AW = 5;

   logic          clk;
   logic          rst;
   logic [AW-1:0] RN1;
   logic [AW-1:0] RN2;
   logic [AW-1:0] RN1_EX;
   logic          WriteReg_EX;
   logic          WriteR0_EX;
   logic          Reg_Forwarding1;
   logic          Reg_Forwarding2;
   logic          Mem_Forwarding1;
   logic          Mem_Forwarding2;

   typedef struct {
      string      tag;
      logic [3:0] expected;
   } expect_t;

   expect_t scoreQ[$];
   int compareCount = 0;
   int mismatchCount = 0;

   logic [AW-1:0] modelDest;
   logic          modelWr;
   logic          modelR0;

   register_forward #(.AW(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .RN1             (RN1),
      .RN2             (RN2),
      .RN1_EX          (RN1_EX),
      .WriteReg_EX     (WriteReg_EX),
      .WriteR0_EX      (WriteR0_EX),
      .Reg_Forwarding1 (Reg_Forwarding1),
      .Reg_Forwarding2 (Reg_Forwarding2),
      .Mem_Forwarding1 (Mem_Forwarding1),
      .Mem_Forwarding2 (Mem_Forwarding2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference copy of the previous EX writer, cleared asynchronously by reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         modelDest <= '0;
         modelWr   <= 1'b0;
         modelR0   <= 1'b0;
      end else begin
         modelDest <= RN1_EX;
         modelWr   <= WriteReg_EX;
         modelR0   <= WriteR0_EX;
      end
   end

   function automatic logic exHit(input logic [AW-1:0] rn);
      return (WriteReg_EX && rn == RN1_EX) || (WriteR0_EX && rn == 0);
   endfunction

   function automatic logic memHit(input logic [AW-1:0] rn);
      return (modelWr && rn == modelDest) || (modelR0 && rn == 0);
   endfunction

   // Packed as {Reg_Forwarding1, Reg_Forwarding2, Mem_Forwarding1, Mem_Forwarding2}.
   function automatic logic [3:0] predict();
      logic e1, e2;
      e1 = exHit(RN1);
      e2 = exHit(RN2);
      return {e1, e2, memHit(RN1) && !e1, memHit(RN2) && !e2};
   endfunction

   function automatic logic [3:0] observed();
      return {Reg_Forwarding1, Reg_Forwarding2, Mem_Forwarding1, Mem_Forwarding2};
   endfunction

   task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] required);
      compareCount++;
      if (actual !== required) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %b, expected %b", tag, actual, required);
      end
   endtask

   // Pops every pending prediction and compares it with the DUT outputs now.
   task automatic drainScoreboard();
      expect_t e;
      while (scoreQ.size() > 0) begin
         e = scoreQ.pop_front();
         checkOutput(e.tag, observed(), e.expected);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic [AW-1:0] rn1, input logic [AW-1:0] rn2,
                                input logic [AW-1:0] rnEx, input logic wr, input logic r0);
      expect_t e;
      RN1         = rn1;
      RN2         = rn2;
      RN1_EX      = rnEx;
      WriteReg_EX = wr;
      WriteR0_EX  = r0;
      #1;
      e.tag      = tag;
      e.expected = predict();
      scoreQ.push_back(e);
      drainScoreboard();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      RN1 = '0; RN2 = '0; RN1_EX = '0; WriteReg_EX = 1'b0; WriteR0_EX = 1'b0;
      #1;
      checkOutput("reset_idle", observed(), 4'b0000);

      // Reg forwarding keeps following inputs while reset is held.
      applyStimulus("reset_ex_live", 5'h0A, 5'h01, 5'h0A, 1'b1, 1'b0);
      checkOutput("reset_ex_live_d", observed(), 4'b1000);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus("req028", 5'h0A, 5'h0F, 5'h0A, 1'b1, 1'b0);
      checkOutput("req028_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0010);
      applyStimulus("req029", 5'h05, 5'h0C, 5'h0C, 1'b1, 1'b0);
      checkOutput("req029_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0001);
      applyStimulus("req030a", 5'h00, 5'h00, 5'h03, 1'b0, 1'b1);
      checkOutput("req030a_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0011);
      applyStimulus("req030b", 5'h03, 5'h03, 5'h03, 1'b0, 1'b1);
      checkOutput("req030b_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0000);
      applyStimulus("r0_real", 5'h00, 5'h04, 5'h00, 1'b1, 1'b0);
      checkOutput("r0_real_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0010);
      applyStimulus("both_en", 5'h00, 5'h09, 5'h09, 1'b1, 1'b1);
      checkOutput("both_en_d", {2'b00, Reg_Forwarding1, Reg_Forwarding2}, 4'b0011);
      applyStimulus("no_en", 5'h00, 5'h09, 5'h09, 1'b0, 1'b0);

      // MEM forwarding one cycle after a write of register 7.
      @(negedge clk);
      applyStimulus("req031_k", 5'h01, 5'h02, 5'h07, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus("req031", 5'h07, 5'h02, 5'h00, 1'b0, 1'b0);
      checkOutput("req031_d", {2'b00, Reg_Forwarding1, Mem_Forwarding1}, 4'b0001);
      applyStimulus("same_rn", 5'h07, 5'h07, 5'h00, 1'b0, 1'b0);
      checkOutput("same_rn_d", {2'b00, Mem_Forwarding1, Mem_Forwarding2}, 4'b0011);
      applyStimulus("req032", 5'h07, 5'h02, 5'h07, 1'b1, 1'b0);
      checkOutput("req032_d", {2'b00, Reg_Forwarding1, Mem_Forwarding1}, 4'b0010);

      // Asynchronous reset between edges drops the MEM writer at once.
      @(negedge clk);
      applyStimulus("req033_pre", 5'h07, 5'h02, 5'h00, 1'b0, 1'b0);
      checkOutput("req033_pre_d", {3'b000, Mem_Forwarding1}, 4'b0001);
      #1 rst = 1'b1;
      #1;
      checkOutput("req033_d", {3'b000, Mem_Forwarding1}, 4'b0000);
      scoreQ.push_back('{"req033_sb", predict()});
      drainScoreboard();
      #1 rst = 1'b0;
      #1;
      checkOutput("req027_discard", {3'b000, Mem_Forwarding1}, 4'b0000);

      // First edge after reset loads normally.
      @(negedge clk);
      applyStimulus("req026_k", 5'h01, 5'h02, 5'h07, 1'b1, 1'b0);
      @(negedge clk);
      applyStimulus("req026", 5'h07, 5'h02, 5'h00, 1'b0, 1'b0);
      checkOutput("req026_d", {3'b000, Mem_Forwarding1}, 4'b0001);

      // Random traffic on a small register range to provoke frequent matches.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         applyStimulus("random", AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                       AW'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 31) == 0) begin
            #1 rst = 1'b1;
            #1;
            scoreQ.push_back('{"random_rst", predict()});
            drainScoreboard();
            #1 rst = 1'b0;
         end
      end

      @(negedge clk);
      drainScoreboard();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
